instr_fetch_unit: RTL

//  Fetch stage feeding the processor's DECODE step. On request, reads one 32-bit RISC-V

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads one 32-bit instruction as four little-endian byte
// reads from the byte-wide system_ram port and reports completion or an address fault.
module instr_fetch_unit #(
   parameter int ADDR_W      = 16,
   parameter int RAM_LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [31:0]       pc,
   output logic              fetch_busy,
   output logic              fetch_done,
   output logic              fetch_fault,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rden,
   output logic              mem_wren,
   output logic [3:0]        mem_byte_en,
   input  logic [7:0]        mem_q,
   output logic [2:0]        dbg_state
);

   // Request handshake: fetch_req/pc are sampled only while fetch_busy is low; a request
   // seen in IDLE is accepted on that edge and ends with exactly one fetch_done or
   // fetch_fault pulse. Requests raised while busy are dropped, never queued.

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4,
      FAULT   = 3'd5
   } state_t;

   localparam int WC_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] base;
   logic [1:0]        byte_idx;
   logic [WC_W-1:0]   wait_cnt;
   logic [23:0]       data_buf;
   logic              pc_ok;

   // Aligned and inside the RAM window; an aligned base can never wrap across base+3.
   assign pc_ok = (pc[1:0] == 2'b00) && ((pc >> ADDR_W) == 32'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (fetch_req) begin
               state_nxt = pc_ok ? ISSUE : FAULT;
            end
         end
         ISSUE:   state_nxt = WAIT;
         WAIT: begin
            if (wait_cnt == WC_W'(RAM_LATENCY - 1)) begin
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: state_nxt = (byte_idx == 2'd3) ? DONE : ISSUE;
         DONE:    state_nxt = IDLE;
         FAULT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base     <= '0;
         byte_idx <= 2'd0;
         wait_cnt <= '0;
         data_buf <= 24'd0;
         instr    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (fetch_req && pc_ok) begin
                  base     <= pc[ADDR_W-1:0];
                  byte_idx <= 2'd0;
               end
            end
            ISSUE: wait_cnt <= '0;
            WAIT:  wait_cnt <= wait_cnt + 1'b1;
            CAPTURE: begin
               // The last byte goes straight into instr so the word is valid while done is high.
               case (byte_idx)
                  2'd0: data_buf[7:0]   <= mem_q;
                  2'd1: data_buf[15:8]  <= mem_q;
                  2'd2: data_buf[23:16] <= mem_q;
                  default: instr        <= {mem_q, data_buf};
               endcase
               if (byte_idx != 2'd3) begin
                  byte_idx <= byte_idx + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_addr    = base + ADDR_W'(byte_idx);
   assign mem_rden    = (state == ISSUE) || (state == WAIT) || (state == CAPTURE);
   assign mem_wren    = 1'b0;
   assign mem_byte_en = 4'b1111;
   assign fetch_busy  = (state != IDLE);
   assign fetch_done  = (state == DONE);
   assign fetch_fault = (state == FAULT);
   assign dbg_state   = state;

endmodule
